// File: rtl/mdio_sta_ctrl.sv
// MDIO station-management master: programmable MDC divider and preamble,
// Clause 22/45 framing, command/response handshake, read turnaround check.
module mdio_sta_ctrl #(
   parameter int CLK_DIV = 10,
   parameter int PRE_LEN = 32,
   parameter int CL45_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_cl45,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_phyad,
   input  logic [4:0]  cmd_regad,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdo,
   output logic        mdo_en,
   input  logic        mdi
);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA} state_t;

   localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);
   localparam logic [4:0] PRE_CNT = (PRE_LEN == 0) ? 5'd0 : 5'(PRE_LEN - 1);

   state_t      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] sh_q, sh_d;
   logic        rd_q, rd_d;
   logic [15:0] rx_q, rx_d;
   logic        ta_err_q, ta_err_d;
   logic        mdc_q, mdc_d;
   logic        mdo_q, mdo_d;
   logic        mdo_en_q, mdo_en_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [15:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        bit_end;
   logic        cl45;

   assign cl45 = (CL45_EN != 0) && cmd_cl45;

   always_comb begin
      state_d     = state_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      rd_d        = rd_q;
      rx_d        = rx_q;
      ta_err_d    = ta_err_q;
      mdc_d       = mdc_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      bit_end     = 1'b0;

      if (state_q == S_IDLE) begin
         if (cmd_valid) begin
            state_d  = (PRE_LEN == 0) ? S_HDR : S_PRE;
            cnt_d    = (PRE_LEN == 0) ? 5'd13 : PRE_CNT;
            // ST, OP, PHYAD, REGAD, write TA, DATA: shifted out MSB first
            sh_d     = {1'b0, ~cl45, cmd_op, cmd_phyad, cmd_regad, 2'b10, cmd_wdata};
            rd_d     = cmd_op[1];
            div_d    = '0;
            mdc_d    = 1'b0;
            ta_err_d = 1'b0;
         end
      end else if (div_q == DIV_MAX) begin
         div_d = '0;
         mdc_d = ~mdc_q;
         if (!mdc_q) begin
            if (rd_q && state_q == S_TA && cnt_q == 5'd0) ta_err_d = mdi;
            if (rd_q && state_q == S_DATA) rx_d = {rx_q[14:0], mdi};
         end else begin
            bit_end = 1'b1;
         end
      end else begin
         div_d = div_q + 8'd1;
      end

      if (bit_end) begin
         if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
            if (state_q != S_PRE) sh_d = sh_q << 1;
         end else begin
            unique case (state_q)
               S_PRE: begin
                  state_d = S_HDR;
                  cnt_d   = 5'd13;
               end
               S_HDR: begin
                  state_d = S_TA;
                  cnt_d   = 5'd1;
                  sh_d    = sh_q << 1;
               end
               S_TA: begin
                  state_d = S_DATA;
                  cnt_d   = 5'd15;
                  sh_d    = sh_q << 1;
               end
               default: begin
                  state_d     = S_IDLE;
                  rsp_valid_d = 1'b1;
                  if (rd_q) begin
                     rsp_rdata_d = rx_q;
                     rsp_err_d   = ta_err_q;
                  end else begin
                     rsp_err_d   = 1'b0;
                  end
               end
            endcase
         end
      end

      // Pad outputs follow the next state so they change only at bit start.
      mdo_d    = 1'b1;
      mdo_en_d = 1'b0;
      if (state_d != S_IDLE) begin
         mdo_en_d = !(rd_d && (state_d == S_TA || state_d == S_DATA));
         mdo_d    = (state_d == S_PRE) || !mdo_en_d || sh_d[31];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         cnt_q       <= '0;
         sh_q        <= '0;
         rd_q        <= 1'b0;
         rx_q        <= '0;
         ta_err_q    <= 1'b0;
         mdc_q       <= 1'b0;
         mdo_q       <= 1'b1;
         mdo_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         rd_q        <= rd_d;
         rx_q        <= rx_d;
         ta_err_q    <= ta_err_d;
         mdc_q       <= mdc_d;
         mdo_q       <= mdo_d;
         mdo_en_q    <= mdo_en_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign mdc       = mdc_q;
   assign mdo       = mdo_q;
   assign mdo_en    = mdo_en_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mdio_sta_ctrl.sv
// Bench for mdio_sta_ctrl: one DUT with a 32-bit preamble, one with none,
// both at CLK_DIV=2; a per-bit frame model and PHY responder drive the checks.
module tb_mdio_sta_ctrl;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_cl45 = 1'b0;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_phyad = '0;
   logic [4:0]  cmd_regad = '0;
   logic [15:0] cmd_wdata = '0;
   logic        mdi = 1'b1;

   logic        cv_a, cv_b;
   logic        ready_a, rv_a, err_a, busy_a, mdc_a, mdo_a, en_a;
   logic        ready_b, rv_b, err_b, busy_b, mdc_b, mdo_b, en_b;
   logic [15:0] rdata_a, rdata_b;

   logic        v_ready, v_rv, v_err, v_busy, v_mdc, v_mdo, v_en;
   logic [15:0] v_rdata;

   int errors = 0;
   int checks = 0;
   int pulses_a = 0;
   logic [15:0] model_rd [2];

   always #5 clk = ~clk;

   assign cv_a = cmd_valid & ~sel;
   assign cv_b = cmd_valid & sel;

   mdio_sta_ctrl #(.CLK_DIV(D), .PRE_LEN(32), .CL45_EN(1)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(cv_a), .cmd_ready(ready_a),
      .cmd_cl45(cmd_cl45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad),
      .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata), .rsp_valid(rv_a),
      .rsp_rdata(rdata_a), .rsp_err(err_a), .busy(busy_a), .mdc(mdc_a),
      .mdo(mdo_a), .mdo_en(en_a), .mdi(mdi)
   );

   mdio_sta_ctrl #(.CLK_DIV(D), .PRE_LEN(0), .CL45_EN(1)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cv_b), .cmd_ready(ready_b),
      .cmd_cl45(cmd_cl45), .cmd_op(cmd_op), .cmd_phyad(cmd_phyad),
      .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata), .rsp_valid(rv_b),
      .rsp_rdata(rdata_b), .rsp_err(err_b), .busy(busy_b), .mdc(mdc_b),
      .mdo(mdo_b), .mdo_en(en_b), .mdi(mdi)
   );

   assign v_ready = sel ? ready_b : ready_a;
   assign v_rv    = sel ? rv_b    : rv_a;
   assign v_err   = sel ? err_b   : err_a;
   assign v_busy  = sel ? busy_b  : busy_a;
   assign v_mdc   = sel ? mdc_b   : mdc_a;
   assign v_mdo   = sel ? mdo_b   : mdo_a;
   assign v_en    = sel ? en_b    : en_a;
   assign v_rdata = sel ? rdata_b : rdata_a;

   always @(negedge clk) if (rv_a) pulses_a++;

   initial begin
      #500_000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Issue one command and follow the whole frame bit by bit against the model.
   task automatic run_frame(input logic cl45, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] regad, input logic [15:0] wd, input logic ta2,
                            input logic [15:0] pd, output logic [15:0] g_rdata,
                            output logic g_err, output logic [63:0] g_bits);
      int pre, nbits, total, nbad, waited, i, ph;
      logic exp_bit [64];
      logic exp_en [64];
      logic phy_bit [64];
      logic [31:0] body;
      logic [4:0] e;
      logic [4:0] a;
      string what;
      pre   = sel ? 0 : 32;
      nbits = pre + 32;
      total = nbits * 2 * D;
      body  = {1'b0, !cl45, op, phy, regad, 2'b10, wd};
      for (int n = 0; n < 64; n++) begin
         exp_bit[n] = 1'b1;
         exp_en[n]  = 1'b1;
         phy_bit[n] = 1'b1;
      end
      for (int j = 31; j >= 0; j--) begin
         exp_bit[pre + 31 - j] = body[j];
         exp_en[pre + 31 - j]  = !(op[1] && j < 18);
      end
      phy_bit[pre + 15] = ta2;
      for (int j = 0; j < 16; j++) phy_bit[pre + 16 + j] = pd[15 - j];

      waited = 0;
      while (!v_ready && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      chk("ready before command", v_ready, 1'b1);
      @(negedge clk);
      cmd_cl45 = cl45; cmd_op = op; cmd_phyad = phy; cmd_regad = regad; cmd_wdata = wd;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;

      nbad = 0;
      g_bits = '0;
      what = "";
      for (int k = 0; k <= total; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         a = {v_busy, v_ready, v_rv, v_mdc, v_en};
         if (k < total) begin
            i  = k / (2 * D);
            ph = k % (2 * D);
            if (ph == 0) mdi = op[1] ? phy_bit[i] : 1'b1;
            if (ph == D) g_bits = {g_bits[62:0], v_mdo};
            e = {1'b1, 1'b0, 1'b0, logic'(ph >= D), exp_en[i]};
            if (a !== e || (exp_en[i] && v_mdo !== exp_bit[i])) begin
               if (nbad == 0)
                  what = $sformatf("cycle %0d {busy,rdy,rv,mdc,en,mdo}=%b%b want %b%b",
                                   k, a, v_mdo, e, exp_bit[i]);
               nbad++;
            end
         end else begin
            e = 5'b01100;
            if (a !== e || v_mdo !== 1'b1) begin
               if (nbad == 0)
                  what = $sformatf("completion cycle %0d {busy,rdy,rv,mdc,en,mdo}=%b%b want %b1",
                                   k, a, v_mdo, e);
               nbad++;
            end
         end
      end
      mdi = 1'b1;
      chk($sformatf("frame waveform pre=%0d op=%0d (bad cycles) %s", pre, op, what), nbad, 0);
      g_rdata = v_rdata;
      g_err   = v_err;
      @(posedge clk); #1;
      chk("rsp_valid single cycle", v_rv, 1'b0);
   endtask

   typedef struct {
      logic        sel;
      logic        cl45;
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] wd;
      logic        ta2;
      logic [15:0] pd;
      logic [15:0] exp_rdata;
      logic        exp_err;
      logic        chk_bits;
      logic [63:0] exp_bits;
   } vec_t;

   initial begin
      vec_t tbl [6];
      logic [15:0] g_rdata, x_rdata;
      logic g_err, x_err;
      logic [63:0] g_bits;
      int acc1, rv, acc2, p0, w;

      tbl[0] = '{1'b0, 1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b0, 16'h0000,
                 16'h0000, 1'b0, 1'b1, 64'hFFFF_FFFF_5082_1140};
      tbl[1] = '{1'b0, 1'b0, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h796D,
                 16'h796D, 1'b0, 1'b0, 64'h0};
      tbl[2] = '{1'b0, 1'b1, 2'b10, 5'h03, 5'h01, 16'h0000, 1'b1, 16'h1234,
                 16'h1234, 1'b1, 1'b0, 64'h0};
      tbl[3] = '{1'b1, 1'b1, 2'b00, 5'h02, 5'h03, 16'hABCD, 1'b0, 16'h0000,
                 16'h0000, 1'b0, 1'b1, 64'h0000_0000_010E_ABCD};
      tbl[4] = '{1'b0, 1'b0, 2'b01, 5'h05, 5'h04, 16'hBEEF, 1'b0, 16'h0000,
                 16'h1234, 1'b0, 1'b0, 64'h0};
      tbl[5] = '{1'b1, 1'b1, 2'b11, 5'h1F, 5'h1F, 16'h0000, 1'b0, 16'hA5C3,
                 16'hA5C3, 1'b0, 1'b0, 64'h0};

      repeat (3) @(posedge clk);
      #1;
      sel = 1'b0; #1;
      chk("reset state A", {v_ready, v_busy, v_rv, v_rdata, v_err, v_mdc, v_mdo, v_en},
          {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      sel = 1'b1; #1;
      chk("reset state B", {v_ready, v_busy, v_rv, v_rdata, v_err, v_mdc, v_mdo, v_en},
          {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
      rst = 1'b0;

      for (int t = 0; t < 6; t++) begin
         sel = tbl[t].sel;
         run_frame(tbl[t].cl45, tbl[t].op, tbl[t].phy, tbl[t].regad, tbl[t].wd,
                   tbl[t].ta2, tbl[t].pd, g_rdata, g_err, g_bits);
         chk($sformatf("vec%0d rsp_rdata", t), g_rdata, tbl[t].exp_rdata);
         chk($sformatf("vec%0d rsp_err", t), g_err, tbl[t].exp_err);
         if (tbl[t].chk_bits) chk($sformatf("vec%0d mdo stream", t), g_bits, tbl[t].exp_bits);
         model_rd[tbl[t].sel] = tbl[t].exp_rdata;
      end

      for (int n = 0; n < 8; n++) begin
         logic rc45, rta2;
         logic [1:0] rop;
         logic [4:0] rphy, rreg;
         logic [15:0] rwd, rpd;
         sel  = 1'($urandom_range(0, 1));
         rc45 = 1'($urandom_range(0, 1));
         rop  = 2'($urandom_range(0, 3));
         rphy = 5'($urandom_range(0, 31));
         rreg = 5'($urandom_range(0, 31));
         rwd  = 16'($urandom_range(0, 65535));
         rpd  = 16'($urandom_range(0, 65535));
         rta2 = ($urandom_range(0, 3) == 0);
         x_rdata = rop[1] ? rpd : model_rd[sel];
         x_err   = rop[1] ? rta2 : 1'b0;
         run_frame(rc45, rop, rphy, rreg, rwd, rta2, rpd, g_rdata, g_err, g_bits);
         chk($sformatf("rand%0d rsp_rdata", n), g_rdata, x_rdata);
         chk($sformatf("rand%0d rsp_err", n), g_err, x_err);
         model_rd[sel] = x_rdata;
      end

      // cmd_valid held through completion, then stray pulses while busy
      sel = 1'b0;
      @(negedge clk);
      cmd_cl45 = 1'b0; cmd_op = 2'b01; cmd_phyad = 5'h01; cmd_regad = 5'h00; cmd_wdata = 16'h0F0F;
      p0 = pulses_a;
      cmd_valid = 1'b1;
      acc1 = -1; rv = -1; acc2 = -1;
      for (int n = 0; n < 800 && acc2 < 0; n++) begin
         @(posedge clk); #1;
         if (acc1 < 0) begin
            if (v_busy) acc1 = n;
         end else if (rv < 0) begin
            if (v_rv) rv = n;
         end else if (v_busy) begin
            acc2 = n;
         end
      end
      cmd_valid = 1'b0;
      chk("b2b first frame length", 64'(rv - acc1), 64'd256);
      chk("b2b second accept delay", 64'(acc2 - rv), 64'd1);
      for (int p = 0; p < 3; p++) begin
         repeat (40) @(negedge clk);
         cmd_valid = 1'b1;
         @(negedge clk);
         cmd_valid = 1'b0;
      end
      w = 0;
      while (v_busy && w < 600) begin
         @(negedge clk);
         w++;
      end
      repeat (20) @(negedge clk);
      chk("b2b rsp_valid pulses", 64'(pulses_a - p0), 64'd2);
      chk("idle after b2b", {v_busy, v_ready}, 2'b01);

      // asynchronous reset in the DATA phase of a read
      @(negedge clk);
      cmd_cl45 = 1'b0; cmd_op = 2'b10; cmd_phyad = 5'h01; cmd_regad = 5'h01;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      p0 = pulses_a;
      repeat (52 * 4 + 2) @(posedge clk);
      #2;
      chk("mid-DATA before reset {busy,mdc,en}", {v_busy, v_mdc, v_en}, 3'b110);
      rst = 1'b1;
      #1;
      chk("reset mid-DATA", {v_ready, v_busy, v_rv, v_rdata, v_err, v_mdc, v_mdo, v_en},
          {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0});
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      chk("no rsp_valid after reset", 64'(pulses_a - p0), 64'd0);
      run_frame(1'b0, 2'b10, 5'h02, 5'h03, 16'h0000, 1'b0, 16'h3C5A, g_rdata, g_err, g_bits);
      chk("post-reset read rsp_rdata", g_rdata, 16'h3C5A);
      chk("post-reset read rsp_err", g_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
